// File: rtl/lbdr_reconf_issuer.sv
// Issues one LBDR reconfiguration strobe per accepted PE configuration, then
// waits for a granted header and a granted tail before committing the shadows.
module lbdr_reconf_issuer #(
  parameter logic [7:0]  Rxy_rst     = 8'd60,
  parameter logic [3:0]  Cx_rst      = 4'd15,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_rxy,
  input  logic [3:0] cfg_cx,
  output logic       cfg_ready,
  input  logic [2:0] flit_type,
  input  logic       empty,
  input  logic       grant_N,
  input  logic       grant_E,
  input  logic       grant_W,
  input  logic       grant_S,
  input  logic       grant_L,
  input  logic       Faulty_C_N,
  input  logic       Faulty_C_E,
  input  logic       Faulty_C_W,
  input  logic       Faulty_C_S,
  output logic       Reconfig_command,
  output logic [7:0] Rxy_reconf_PE,
  output logic [3:0] Cx_reconf_PE,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic       fault_override,
  output logic [7:0] cur_rxy,
  output logic [3:0] cur_cx
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 32'd1);

  state_e      state_q, state_d;
  logic        rdy_q;
  logic        rxy_ok_q, rxy_ok_d;
  logic        cx_ok_q, cx_ok_d;
  logic [3:0]  mask_q, mask_d;
  logic        fault_q, fault_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  pe_rxy_q, pe_rxy_d;
  logic [3:0]  pe_cx_q, pe_cx_d;
  logic [7:0]  cur_rxy_q, cur_rxy_d;
  logic [3:0]  cur_cx_q, cur_cx_d;
  logic        done_c, timeout_c;

  logic [3:0] faults;
  logic       grants, hdr_ev, tail_ev;

  assign faults  = {Faulty_C_S, Faulty_C_W, Faulty_C_E, Faulty_C_N};
  assign grants  = grant_N | grant_E | grant_W | grant_S | grant_L;
  assign hdr_ev  = ~empty & grants & (flit_type == 3'b001);
  assign tail_ev = ~empty & grants & (flit_type == 3'b100);

  always_comb begin
    state_d   = state_q;
    rxy_ok_d  = rxy_ok_q;
    cx_ok_d   = cx_ok_q;
    mask_d    = mask_q;
    fault_d   = fault_q;
    cnt_d     = cnt_q;
    pe_rxy_d  = pe_rxy_q;
    pe_cx_d   = pe_cx_q;
    cur_rxy_d = cur_rxy_q;
    cur_cx_d  = cur_cx_q;
    done_c    = 1'b0;
    timeout_c = 1'b0;

    // Fault mask is tracked for the whole ISSUE/WAIT window, including the strobe cycle.
    if (state_q != S_IDLE && |faults) begin
      fault_d = 1'b1;
      mask_d  = faults;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cfg_valid && rdy_q) begin
          pe_rxy_d = cfg_rxy;
          pe_cx_d  = cfg_cx;
          fault_d  = 1'b0;
          mask_d   = '0;
          rxy_ok_d = 1'b0;
          cx_ok_d  = 1'b0;
          cnt_d    = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        rxy_ok_d = rxy_ok_q | hdr_ev;
        cx_ok_d  = cx_ok_q | tail_ev;
        cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        // Completion is evaluated on this cycle's events and wins over timeout.
        if (rxy_ok_d && cx_ok_d) begin
          cur_rxy_d = pe_rxy_q;
          cur_cx_d  = pe_cx_q & ~mask_d;
          done_c    = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_c = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      rxy_ok_q  <= 1'b0;
      cx_ok_q   <= 1'b0;
      mask_q    <= '0;
      fault_q   <= 1'b0;
      cnt_q     <= '0;
      pe_rxy_q  <= Rxy_rst;
      pe_cx_q   <= Cx_rst;
      cur_rxy_q <= Rxy_rst;
      cur_cx_q  <= Cx_rst;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      rxy_ok_q  <= rxy_ok_d;
      cx_ok_q   <= cx_ok_d;
      mask_q    <= mask_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
      pe_rxy_q  <= pe_rxy_d;
      pe_cx_q   <= pe_cx_d;
      cur_rxy_q <= cur_rxy_d;
      cur_cx_q  <= cur_cx_d;
    end
  end

  assign cfg_ready        = rdy_q & (state_q == S_IDLE);
  assign Reconfig_command = (state_q == S_ISSUE);
  assign busy             = (state_q != S_IDLE);
  assign done             = done_c;
  assign timeout_err      = timeout_c;
  assign fault_override   = fault_q;
  assign Rxy_reconf_PE    = pe_rxy_q;
  assign Cx_reconf_PE     = pe_cx_q;
  assign cur_rxy          = cur_rxy_q;
  assign cur_cx           = cur_cx_q;

endmodule

// File: tb/tb_lbdr_reconf_issuer.sv
// Directed bench for lbdr_reconf_issuer: a per-cycle reference model checked on
// every falling edge, plus hand-computed literal checks at key points.
module tb_lbdr_reconf_issuer;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_rxy = '0;
  logic [3:0] cfg_cx = '0;
  logic       cfg_ready;
  logic [2:0] flit_type = '0;
  logic       empty = 1'b1;
  logic       grant_N = 1'b0, grant_E = 1'b0, grant_W = 1'b0, grant_S = 1'b0, grant_L = 1'b0;
  logic       Faulty_C_N = 1'b0, Faulty_C_E = 1'b0, Faulty_C_W = 1'b0, Faulty_C_S = 1'b0;
  logic       Reconfig_command;
  logic [7:0] Rxy_reconf_PE;
  logic [3:0] Cx_reconf_PE;
  logic       busy, done, timeout_err, fault_override;
  logic [7:0] cur_rxy;
  logic [3:0] cur_cx;

  int n_vec = 0;
  int n_err = 0;

  lbdr_reconf_issuer #(.Rxy_rst(8'd60), .Cx_rst(4'd15), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_ready(cfg_ready),
    .flit_type(flit_type), .empty(empty),
    .grant_N(grant_N), .grant_E(grant_E), .grant_W(grant_W), .grant_S(grant_S), .grant_L(grant_L),
    .Faulty_C_N(Faulty_C_N), .Faulty_C_E(Faulty_C_E), .Faulty_C_W(Faulty_C_W), .Faulty_C_S(Faulty_C_S),
    .Reconfig_command(Reconfig_command), .Rxy_reconf_PE(Rxy_reconf_PE), .Cx_reconf_PE(Cx_reconf_PE),
    .busy(busy), .done(done), .timeout_err(timeout_err), .fault_override(fault_override),
    .cur_rxy(cur_rxy), .cur_cx(cur_cx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: m_age counts cycles since acceptance (0 = idle, 1 = strobe
  // cycle, k>=2 = wait cycle number k-1).
  int         m_age;
  bit         m_rdy, m_hdr, m_tail, m_fault;
  logic [3:0] m_mask, e_flt, e_msk;
  logic [7:0] m_pe_rxy, m_cur_rxy;
  logic [3:0] m_pe_cx, m_cur_cx;
  bit         e_hdr, e_tail, e_wait, e_comp, e_to, e_ready;

  always @(negedge clk) begin
    if (reset) begin
      m_age = 0; m_rdy = 0; m_hdr = 0; m_tail = 0; m_fault = 0; m_mask = '0;
      m_pe_rxy = 8'd60; m_cur_rxy = 8'd60; m_pe_cx = 4'd15; m_cur_cx = 4'd15;
    end
    e_flt   = {Faulty_C_S, Faulty_C_W, Faulty_C_E, Faulty_C_N};
    e_wait  = (m_age >= 2);
    e_hdr   = m_hdr || (e_wait && !empty && (flit_type == 3'd1) &&
              (grant_N || grant_E || grant_W || grant_S || grant_L));
    e_tail  = m_tail || (e_wait && !empty && (flit_type == 3'd4) &&
              (grant_N || grant_E || grant_W || grant_S || grant_L));
    e_msk   = (m_age >= 1 && e_flt != 4'd0) ? e_flt : m_mask;
    e_comp  = e_wait && e_hdr && e_tail;
    e_to    = e_wait && !e_comp && (m_age - 1 == TO);
    e_ready = m_rdy && (m_age == 0) && !reset;

    chk("cfg_ready", cfg_ready, e_ready);
    chk("Reconfig_command", Reconfig_command, m_age == 1);
    chk("busy", busy, m_age >= 1);
    chk("done", done, e_comp);
    chk("timeout_err", timeout_err, e_to);
    chk("fault_override", fault_override, m_fault);
    chk("Rxy_reconf_PE", Rxy_reconf_PE, m_pe_rxy);
    chk("Cx_reconf_PE", Cx_reconf_PE, m_pe_cx);
    chk("cur_rxy", cur_rxy, m_cur_rxy);
    chk("cur_cx", cur_cx, m_cur_cx);

    if (!reset) begin
      if (m_age == 0) begin
        if (e_ready && cfg_valid) begin
          m_pe_rxy = cfg_rxy; m_pe_cx = cfg_cx;
          m_fault = 0; m_mask = '0; m_hdr = 0; m_tail = 0; m_age = 1;
        end
      end else begin
        m_mask = e_msk;
        if (e_flt != 4'd0) m_fault = 1;
        if (m_age == 1) m_age = 2;
        else begin
          m_hdr = e_hdr; m_tail = e_tail;
          if (e_comp) begin
            m_cur_rxy = m_pe_rxy; m_cur_cx = m_pe_cx & ~e_msk; m_age = 0;
          end else if (e_to) m_age = 0;
          else m_age++;
        end
      end
      m_rdy = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic no_flit();
    empty = 1'b1; flit_type = 3'd0;
    {grant_N, grant_E, grant_W, grant_S, grant_L} = '0;
  endtask

  task automatic flit(input logic [2:0] t, input logic [4:0] g);
    empty = 1'b0; flit_type = t;
    {grant_N, grant_E, grant_W, grant_S, grant_L} = g;
  endtask

  task automatic offer(input logic [7:0] r, input logic [3:0] c);
    cfg_valid = 1'b1; cfg_rxy = r; cfg_cx = c;
    step();
    cfg_valid = 1'b0;
    #1 chk("strobe_after_accept", Reconfig_command, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_cur_rxy", cur_rxy, 8'd60);
    chk("rst_cur_cx", cur_cx, 4'd15);
    chk("rst_Rxy_PE", Rxy_reconf_PE, 8'd60);
    chk("rst_busy", busy, 1'b0);
    step(); step();
    reset = 1'b0;
    step();
    chk("ready_after_release", cfg_ready, 1'b1);

    // Basic transaction: header then tail.
    offer(8'hA5, 4'h7);
    step();
    chk("strobe_one_cycle", Reconfig_command, 1'b0);
    flit(3'd1, 5'b01000);
    step();
    flit(3'd4, 5'b00001);
    #1 chk("done_on_tail", done, 1'b1);
    step(); no_flit();
    chk("t1_cur_rxy", cur_rxy, 8'hA5);
    chk("t1_cur_cx", cur_cx, 4'h7);

    // Header during the strobe cycle is ignored.
    offer(8'h3C, 4'h9);
    flit(3'd1, 5'b10000);
    step();
    flit(3'd4, 5'b00100);
    #1 chk("t2_no_done_tail_only", done, 1'b0);
    step();
    no_flit();
    chk("t2_still_busy", busy, 1'b1);
    flit(3'd1, 5'b00010);
    #1 chk("t2_done_late_hdr", done, 1'b1);
    step(); no_flit();
    chk("t2_cur_rxy", cur_rxy, 8'h3C);

    // East link fault masks Cx.
    offer(8'h11, 4'hF);
    step();
    Faulty_C_E = 1'b1;
    step();
    Faulty_C_E = 1'b0;
    chk("t3_fault_override", fault_override, 1'b1);
    flit(3'd1, 5'b01000);
    step();
    flit(3'd4, 5'b01000);
    step(); no_flit();
    chk("t3_cur_cx", cur_cx, 4'hD);
    chk("t3_override_sticky", fault_override, 1'b1);

    // Timeout with only a header.
    offer(8'h77, 4'h3);
    chk("t4_override_cleared", fault_override, 1'b0);
    for (int w = 1; w <= TO; w++) begin
      step();
      if (w == 3) flit(3'd1, 5'b00001); else no_flit();
      #1 chk("t4_timeout_cycle", timeout_err, w == TO);
    end
    step();
    chk("t4_ready", cfg_ready, 1'b1);
    chk("t4_cur_rxy_kept", cur_rxy, 8'h11);
    chk("t4_cur_cx_kept", cur_cx, 4'hD);

    // cfg_valid held while busy.
    cfg_valid = 1'b1; cfg_rxy = 8'h5A; cfg_cx = 4'h6;
    step();
    cfg_rxy = 8'hC3; cfg_cx = 4'hA;
    step();
    flit(3'd1, 5'b00100);
    chk("t5_pe_held", Rxy_reconf_PE, 8'h5A);
    step();
    flit(3'd4, 5'b00100);
    step(); no_flit();
    chk("t5_no_second_strobe", Reconfig_command, 1'b0);
    chk("t5_cur_rxy", cur_rxy, 8'h5A);
    step();
    cfg_valid = 1'b0;
    chk("t5_second_accept", Rxy_reconf_PE, 8'hC3);
    step(); flit(3'd1, 5'b00100);
    step(); flit(3'd4, 5'b00100);
    step(); no_flit();
    chk("t5_cur_cx", cur_cx, 4'hA);

    // Completion on the final wait cycle beats timeout.
    offer(8'h42, 4'h5);
    for (int w = 1; w <= TO; w++) begin
      step();
      if (w == TO - 1) flit(3'd1, 5'b10000);
      else if (w == TO) flit(3'd4, 5'b10000);
      else no_flit();
    end
    #1 chk("t7_done_wins", done, 1'b1);
    chk("t7_no_timeout", timeout_err, 1'b0);
    step(); no_flit();
    chk("t7_cur_rxy", cur_rxy, 8'h42);

    // Reset mid-WAIT.
    offer(8'hEE, 4'h1);
    step();
    flit(3'd1, 5'b00010);
    step(); no_flit();
    reset = 1'b1;
    #1;
    chk("t6_cur_rxy", cur_rxy, 8'd60);
    chk("t6_cur_cx", cur_cx, 4'd15);
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_Rxy_PE", Rxy_reconf_PE, 8'd60);
    chk("t6_ready", cfg_ready, 1'b0);
    step();
    reset = 1'b0;
    step();
    chk("t6_ready_after", cfg_ready, 1'b1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lbdr_reconf_issuer.md
LBDR_RECONF_ISSUER -- requirements
Module: lbdr_reconf_issuer

Interface
REQ-001 SHALL have parameter Rxy_rst, default 60, meaning LBDR reset turn-permission bits and initial shadow.
REQ-002 SHALL have parameter Cx_rst, default 15, meaning LBDR reset connectivity bits and initial shadow.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1024, meaning the maximum number of WAIT cycles, range 1..65535.
REQ-004 SHALL provide: clk  input  1  sole clock, rising edge.
REQ-005 SHALL provide: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide: cfg_valid  input  1  PE offers a new configuration.
REQ-007 SHALL provide: cfg_rxy  input  8  requested Rxy.
REQ-008 SHALL provide: cfg_cx  input  4  requested Cx, as {S,W,E,N}.
REQ-009 SHALL provide: cfg_ready  output  1  block accepts a configuration.
REQ-010 SHALL provide: flit_type  input  3  input-FIFO head flit type (001 header, 100 tail).
REQ-011 SHALL provide: empty  input  1  input FIFO empty.
REQ-012 SHALL provide: grant_N, grant_E, grant_W, grant_S, grant_L  input  1 each  allocator grants for this input port.
REQ-013 SHALL provide: Faulty_C_N, Faulty_C_E, Faulty_C_W, Faulty_C_S  input  1 each  link fault indications.
REQ-014 SHALL provide: Reconfig_command  output  1  one-cycle reconfiguration strobe to LBDR.
REQ-015 SHALL provide: Rxy_reconf_PE  output  8  Rxy value to LBDR.
REQ-016 SHALL provide: Cx_reconf_PE  output  4  Cx value to LBDR.
REQ-017 SHALL provide: busy, done, timeout_err, fault_override  output  1 each  status outputs.
REQ-018 SHALL provide: cur_rxy  output  8  shadow of the applied Rxy.
REQ-019 SHALL provide: cur_cx  output  4  shadow of the applied Cx.

Function
REQ-020 SHALL implement states IDLE, ISSUE and WAIT; cfg_ready=1 only in IDLE; busy=1 in ISSUE and WAIT.
REQ-021 SHALL, in IDLE with cfg_valid=1, latch cfg_rxy into Rxy_reconf_PE and cfg_cx into Cx_reconf_PE, clear fault_override, and enter ISSUE.
REQ-022 SHALL drive Reconfig_command=1 for exactly the one ISSUE cycle, then enter WAIT with the timeout counter at 0.
REQ-023 SHALL hold Rxy_reconf_PE and Cx_reconf_PE stable from latch until the next accepted configuration.
REQ-024 SHALL define grants as the OR of the five grant inputs.
REQ-025 SHALL, in WAIT, set flag rxy_ok on the first cycle with flit_type=001, empty=0 and grants=1.
REQ-026 SHALL, in WAIT, set flag cx_ok on the first cycle with flit_type=100, empty=0 and grants=1.
REQ-027 SHALL ignore header and tail events that occur in the ISSUE cycle, because LBDR arms one cycle after the strobe.
REQ-028 SHALL, when any Faulty_C_* is 1 in ISSUE or WAIT, set fault_override (sticky until the next accept) and capture the mask M={S,W,E,N}.
REQ-029 SHALL, when rxy_ok and cx_ok are both set (updates included), update cur_rxy with Rxy_reconf_PE and cur_cx with Cx_reconf_PE&~M (M=0 if no fault), pulse done for 1 cycle, and enter IDLE.
REQ-030 SHALL increment the 16-bit timeout counter each WAIT cycle and never wrap it.
REQ-031 SHALL, when the counter reaches TIMEOUT_CYC-1 without completion, pulse timeout_err for 1 cycle, enter IDLE, and leave the shadows unchanged.
REQ-032 SHALL give completion priority over timeout when both occur in the same cycle.
REQ-033 SHALL never produce a second Reconfig_command before done or timeout_err.

Reset
REQ-034 SHALL, on reset=1 (asynchronous), go to IDLE and clear rxy_ok, cx_ok, M and the counter.
REQ-035 SHALL, on reset, set Reconfig_command, busy, done, timeout_err and fault_override to 0.
REQ-036 SHALL, on reset, set Rxy_reconf_PE=cur_rxy=Rxy_rst and Cx_reconf_PE=cur_cx=Cx_rst.
REQ-037 SHALL drive cfg_ready=0 while reset=1 and cfg_ready=1 from the first clock after release.
REQ-038 SHALL, on reset during ISSUE or WAIT, abort the operation with no done pulse and the shadows restored to the reset values.

Verification
REQ-039 SHALL verify: cfg_valid with rxy=0xA5, cx=0x7 -> Reconfig_command high 1 cycle; header granted then tail granted -> done pulse, cur_rxy=0xA5, cur_cx=0x7.
REQ-040 SHALL verify: header granted in the ISSUE cycle, then only a tail -> still WAIT; a later header -> done.
REQ-041 SHALL verify: Faulty_C_E=1 during WAIT with cx=0xF -> fault_override=1 and cur_cx=0xD at done.
REQ-042 SHALL verify: TIMEOUT_CYC=8 with no flits -> timeout_err on WAIT cycle 8, then IDLE, shadows unchanged, cfg_ready=1.
REQ-043 SHALL verify: cfg_valid held high while busy -> no second Reconfig_command; the new configuration is accepted only after done.
REQ-044 SHALL verify: reset asserted mid-WAIT -> outputs return to the reset values immediately (cur_rxy=60, cur_cx=15) with no done pulse.
